mt_func_exec: RTL

Drive-side function executor for the MT (TM03/TU45-style) slave. It accepts the function code and GO strobe that the host writes into MTCS1 and runs a command state machine that hands each operation to the tape emulator over a request/acknowledge/done handshake. It drives drive-ready `mtDRY`, which MTCS1 uses to gate further function writes and to derive its GO bit. It also owns the frame counter, and the attention, error and positioning status that the MT status registers report.

---
 rtl/mt_pkg.sv | 59 +++++
 rtl/mt_frame_counter.sv | 34 +++
 rtl/mt_func_exec.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mt_pkg.sv
// Shared definitions for the MT drive-side function executor: function codes,
// executor state encoding and function classification helpers.
package mt_pkg;

    localparam logic [4:0] FN_NOP    = 5'o00;
    localparam logic [4:0] FN_UNLOAD = 5'o01;
    localparam logic [4:0] FN_REWIND = 5'o03;
    localparam logic [4:0] FN_DRVCLR = 5'o04;
    localparam logic [4:0] FN_PRESET = 5'o10;
    localparam logic [4:0] FN_ERASE  = 5'o12;
    localparam logic [4:0] FN_WRTM   = 5'o13;
    localparam logic [4:0] FN_SPCF   = 5'o14;
    localparam logic [4:0] FN_SPCR   = 5'o15;
    localparam logic [4:0] FN_WCHKF  = 5'o24;
    localparam logic [4:0] FN_WCHKR  = 5'o27;
    localparam logic [4:0] FN_WRF    = 5'o30;
    localparam logic [4:0] FN_RDF    = 5'o34;
    localparam logic [4:0] FN_RDR    = 5'o37;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic fn_is_legal(input logic [4:0] fun);
        logic ok;
        case (fun)
            FN_NOP, FN_UNLOAD, FN_REWIND, FN_DRVCLR, FN_PRESET,
            FN_ERASE, FN_WRTM, FN_SPCF, FN_SPCR,
            FN_WCHKF, FN_WCHKR, FN_WRF, FN_RDF, FN_RDR: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Data-transfer functions occupy the codes from 24 octal upward.
    function automatic logic fn_is_data(input logic [4:0] fun);
        return (fun >= FN_WCHKF);
    endfunction

    function automatic logic fn_is_pos(input logic [4:0] fun);
        logic pos;
        case (fun)
            FN_UNLOAD, FN_REWIND, FN_SPCF, FN_SPCR: pos = 1'b1;
            default:                                pos = 1'b0;
        endcase
        return pos;
    endfunction

    function automatic logic fn_is_space(input logic [4:0] fun);
        return (fun == FN_SPCF) || (fun == FN_SPCR);
    endfunction

    // Legal functions other than NOP, DRVCLR and PRESET are handed to the emulator.
    function automatic logic fn_needs_req(input logic [4:0] fun);
        return fn_is_legal(fun) && (fun != FN_NOP) && (fun != FN_DRVCLR) && (fun != FN_PRESET);
    endfunction

endpackage

// File: rtl/mt_frame_counter.sv
// 16-bit frame counter with clear, load and increment; o_zero flags an
// increment that wraps the count from FFFF to 0000 in this cycle.
module mt_frame_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic        i_inc,
    output logic [15:0] o_count,
    output logic        o_zero
);

    logic [15:0] r_count;

    // Clear beats load beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'h0000;
        end else if (i_clr) begin
            r_count <= 16'h0000;
        end else if (i_load) begin
            r_count <= i_data;
        end else if (i_inc) begin
            r_count <= r_count + 16'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_zero  = i_inc && !i_clr && !i_load && (r_count == 16'hFFFF);

endmodule

// File: rtl/mt_func_exec.sv
// MT drive-side function executor: command FSM, emulator handshake and status.
// Optional MT_TIMEOUT_EN adds an acknowledge timeout that reports OPI.
module mt_func_exec
    import mt_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtGO,
    input  logic [4:0]  mtFUN,
    input  logic        mtWRFC,
    input  logic [15:0] mtDATAI,
    input  logic        mtACK,
    input  logic        mtRECPULSE,
    input  logic        mtDONE,
    input  logic        mtERRI,
    output logic        mtREQ,
    output logic [4:0]  mtFUNO,
    output logic        mtABORT,
    output logic        mtDRY,
    output logic        mtPIP,
    output logic        mtATA,
    output logic        mtERR,
    output logic        mtILF,
    output logic        mtRMR,
    output logic        mtOPI,
    output logic [15:0] mtFC
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_req;
    logic        r_dry;
    logic        r_abort;
    logic        r_pip;
    logic        r_ata;
    logic        r_err;
    logic        r_ilf;
    logic        r_rmr;
    logic        r_opi;
    logic        r_done_err;
    logic [4:0]  r_funo;
    logic        w_idle;
    logic        w_go_drvclr;
    logic        w_finish;
    logic        w_timeout;
    logic        w_fc_clr;
    logic        w_fc_load;
    logic        w_fc_inc;
    logic        w_fc_zero;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_go_drvclr = mtGO && (mtFUN == FN_DRVCLR);

`ifdef MT_TIMEOUT_EN
    logic [23:0] r_timer;

    // Cycles spent waiting in REQ; restarts each time REQ is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= 24'd0;
        end else if (r_state == ST_REQ) begin
            r_timer <= r_timer + 24'd1;
        end else begin
            r_timer <= 24'd0;
        end
    end

    assign w_timeout = (r_state == ST_REQ) && !mtACK && (r_timer == (TIMEOUT - 24'd1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    assign w_fc_clr  = w_idle && mtGO && (mtFUN == FN_PRESET);
    assign w_fc_load = w_idle && mtWRFC;
    assign w_fc_inc  = mtRECPULSE && !w_go_drvclr &&
                       ((r_state == ST_WAIT) || ((r_state == ST_REQ) && mtACK));

    mt_frame_counter u_fc (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_fc_clr),
        .i_load  (w_fc_load),
        .i_data  (mtDATAI),
        .i_inc   (w_fc_inc),
        .o_count (mtFC),
        .o_zero  (w_fc_zero)
    );

    // Space ops also end when the frame count wraps to zero.
    assign w_finish = mtDONE || (fn_is_space(r_funo) && w_fc_zero);

    // Next-state selection for the command FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mtGO && fn_needs_req(mtFUN)) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_go_drvclr) begin
                    w_state_nxt = ST_IDLE;
                end else if (mtACK) begin
                    w_state_nxt = w_finish ? ST_DONE : ST_WAIT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (w_go_drvclr) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_finish) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, handshake outputs and the error flag captured alongside mtDONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_dry      <= 1'b1;
            r_done_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == ST_REQ);
            r_dry   <= (w_state_nxt == ST_IDLE);
            if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
                r_done_err <= mtDONE && mtERRI;
            end else begin
                r_done_err <= r_done_err;
            end
        end
    end

    // Command acceptance, completion and drive-clear effects on the status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_abort <= 1'b0;
            r_pip   <= 1'b0;
            r_ata   <= 1'b0;
            r_err   <= 1'b0;
            r_ilf   <= 1'b0;
            r_rmr   <= 1'b0;
            r_opi   <= 1'b0;
            r_funo  <= 5'd0;
        end else if (w_idle) begin
            r_abort <= 1'b0;
            if (w_go_drvclr) begin
                r_ata <= 1'b0;
                r_err <= 1'b0;
                r_ilf <= 1'b0;
                r_rmr <= 1'b0;
                r_opi <= 1'b0;
            end else if (mtGO && !fn_is_legal(mtFUN)) begin
                r_ilf <= 1'b1;
                r_err <= 1'b1;
                r_ata <= 1'b1;
            end else if (mtGO && fn_needs_req(mtFUN)) begin
                r_funo <= mtFUN;
                r_pip  <= fn_is_pos(mtFUN);
            end else begin
                r_funo <= r_funo;
            end
        end else if (w_go_drvclr) begin
            r_abort <= 1'b1;
            r_pip   <= 1'b0;
            r_ata   <= 1'b0;
            r_err   <= 1'b0;
            r_ilf   <= 1'b0;
            r_rmr   <= 1'b0;
            r_opi   <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            if (mtGO || mtWRFC) begin
                r_rmr <= 1'b1;
            end
            if (w_timeout) begin
                r_opi <= 1'b1;
                r_err <= 1'b1;
                r_ata <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_pip <= 1'b0;
                if (r_done_err || !fn_is_data(r_funo)) begin
                    r_ata <= 1'b1;
                end
                if (r_done_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign mtREQ   = r_req;
    assign mtFUNO  = r_funo;
    assign mtABORT = r_abort;
    assign mtDRY   = r_dry;
    assign mtPIP   = r_pip;
    assign mtATA   = r_ata;
    assign mtERR   = r_err;
    assign mtILF   = r_ilf;
    assign mtRMR   = r_rmr;
    assign mtOPI   = r_opi;

endmodule
